// File: rtl/rx_fifo_bus_poller_if.sv
// rtl/rx_fifo_bus_poller_if.sv - shared FIFO read bus plus downstream LocalLink port
interface rx_fifo_bus_poller_if;
  // Shared tri-state FIFO read bus
  logic [5:0] rd_addr;
  logic [7:0] rd_data_in;
  logic       rd_sof_n_in;
  logic       rd_eof_n_in;
  logic       rd_src_rdy_n_in;
  logic       rd_dst_rdy_n;
  // Downstream LocalLink port
  logic [7:0] out_data;
  logic       out_sof_n;
  logic       out_eof_n;
  logic       out_src_rdy_n;
  logic       out_dst_rdy_n;
  logic [3:0] out_port;

  modport master (
    output rd_addr, rd_dst_rdy_n,
    input  rd_data_in, rd_sof_n_in, rd_eof_n_in, rd_src_rdy_n_in,
    output out_data, out_sof_n, out_eof_n, out_src_rdy_n, out_port,
    input  out_dst_rdy_n
  );

  modport slave (
    input  rd_addr, rd_dst_rdy_n,
    output rd_data_in, rd_sof_n_in, rd_eof_n_in, rd_src_rdy_n_in,
    input  out_data, out_sof_n, out_eof_n, out_src_rdy_n, out_port,
    output out_dst_rdy_n
  );
endinterface

// File: rtl/rx_fifo_bus_poller.sv
// rtl/rx_fifo_bus_poller.sv - round-robin read master forwarding one frame per FIFO visit
module rx_fifo_bus_poller #(
  parameter logic [5:0] BaseAddr = 6'h30,
  parameter int         NumPorts = 8,
  parameter logic [5:0] IdleAddr = 6'h00
) (
  input  logic                 rd_clk,
  input  logic                 rd_sreset,
  input  logic                 enable,
  rx_fifo_bus_poller_if.master bus,
  output logic [15:0]          frame_count,
  output logic [7:0]           desync_count
);

  // SEL1/SEL2 cover the FIFO's registered chip-select and its registered dst-ready gate.
  typedef enum logic [2:0] {
    ST_IDLE, ST_SEL1, ST_SEL2, ST_PROBE, ST_XFER, ST_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  out_port_q, out_port_d;
  logic [15:0] frame_q, frame_d;
  logic [7:0]  desync_q, desync_d;
  logic [3:0]  idx_inc;

  logic [5:0]  rd_addr_c;
  logic        rd_dst_rdy_n_c;
  logic [7:0]  out_data_c;
  logic        out_sof_n_c;
  logic        out_eof_n_c;
  logic        out_src_rdy_n_c;

  assign idx_inc = (idx_q == 4'(NumPorts - 1)) ? 4'd0 : idx_q + 4'd1;

  // Next-state, bus select and downstream pass-through decode
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    out_port_d      = out_port_q;
    frame_d         = frame_q;
    desync_d        = desync_q;
    rd_addr_c       = BaseAddr + {2'b00, idx_q};
    rd_dst_rdy_n_c  = 1'b1;
    out_data_c      = 8'h00;
    out_sof_n_c     = 1'b1;
    out_eof_n_c     = 1'b1;
    out_src_rdy_n_c = 1'b1;

    case (state_q)
      ST_IDLE: begin
        rd_addr_c = IdleAddr;
        if (enable) state_d = ST_SEL1;
      end
      ST_SEL1: state_d = enable ? ST_SEL2 : ST_IDLE;
      ST_SEL2: state_d = enable ? ST_PROBE : ST_IDLE;
      ST_PROBE: begin
        if (bus.rd_src_rdy_n_in) begin
          // Empty port: move on
          idx_d   = idx_inc;
          state_d = enable ? ST_SEL1 : ST_IDLE;
        end else if (!enable) begin
          // Leave the waiting frame in place; it is picked up on a later visit
          state_d = ST_IDLE;
        end else if (!bus.rd_sof_n_in) begin
          state_d    = ST_XFER;
          out_port_d = idx_q;
        end else begin
          state_d = ST_DRAIN;
          if (desync_q != 8'hFF) desync_d = desync_q + 8'd1;
        end
      end
      ST_XFER: begin
        out_data_c      = bus.rd_data_in;
        out_sof_n_c     = bus.rd_sof_n_in;
        out_eof_n_c     = bus.rd_eof_n_in;
        out_src_rdy_n_c = bus.rd_src_rdy_n_in;
        rd_dst_rdy_n_c  = bus.out_dst_rdy_n;
        if (!bus.rd_src_rdy_n_in && !bus.out_dst_rdy_n && !bus.rd_eof_n_in) begin
          frame_d = frame_q + 16'd1;
          idx_d   = idx_inc;
          state_d = enable ? ST_SEL1 : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        rd_dst_rdy_n_c = 1'b0;
        if (!bus.rd_src_rdy_n_in && !bus.rd_eof_n_in) begin
          idx_d   = idx_inc;
          state_d = enable ? ST_SEL1 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, port index and counters
  always_ff @(posedge rd_clk) begin
    if (rd_sreset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 4'd0;
      out_port_q <= 4'd0;
      frame_q    <= 16'd0;
      desync_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_port_q <= out_port_d;
      frame_q    <= frame_d;
      desync_q   <= desync_d;
    end
  end

  assign bus.rd_addr       = rd_addr_c;
  assign bus.rd_dst_rdy_n  = rd_dst_rdy_n_c;
  assign bus.out_data      = out_data_c;
  assign bus.out_sof_n     = out_sof_n_c;
  assign bus.out_eof_n     = out_eof_n_c;
  assign bus.out_src_rdy_n = out_src_rdy_n_c;
  assign bus.out_port      = out_port_q;
  assign frame_count       = frame_q;
  assign desync_count      = desync_q;

endmodule

// File: tb/tb_rx_fifo_bus_poller.sv
// tb/tb_rx_fifo_bus_poller.sv - self-checking bench for rx_fifo_bus_poller
module tb_rx_fifo_bus_poller;
  localparam logic [5:0] BASE   = 6'h30;
  localparam int         NP     = 8;
  localparam logic [5:0] IDLE_A = 6'h00;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } beat_t;

  typedef struct {
    int         port;
    int         nbytes;
    bit         sof_ok;
    int         stall;
    int         exp_frames;
    int         exp_desync;
    logic [5:0] exp_next;
  } vec_t;

  logic        rd_clk    = 1'b0;
  logic        rd_sreset = 1'b1;
  logic        enable    = 1'b0;
  logic [15:0] frame_count;
  logic [7:0]  desync_count;

  rx_fifo_bus_poller_if bus();

  rx_fifo_bus_poller #(.BaseAddr(BASE), .NumPorts(NP), .IdleAddr(IDLE_A)) dut (
    .rd_clk      (rd_clk),
    .rd_sreset   (rd_sreset),
    .enable      (enable),
    .bus         (bus),
    .frame_count (frame_count),
    .desync_count(desync_count)
  );

  always #5 rd_clk = ~rd_clk;

  int errors = 0;
  int checks = 0;

  // FIFO contents per port, downstream capture, and bus bookkeeping
  beat_t       pq [NP][$];
  logic [13:0] mon_q [$];
  bit          pend_beat = 1'b0;
  logic [5:0]  pend_addr = IDLE_A;
  int          stall_mode = 0;
  int          mirror_err = 0;

  function automatic int port_of(input logic [5:0] a);
    if (int'(a) >= int'(BASE) && int'(a) < int'(BASE) + NP) return int'(a) - int'(BASE);
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge rd_clk);
    #2;
  endtask

  task automatic do_reset();
    enable     = 1'b0;
    stall_mode = 0;
    rd_sreset  = 1'b1;
    for (int i = 0; i < NP; i++) pq[i].delete();
    step();
    step();
    rd_sreset = 1'b0;
    mon_q.delete();
  endtask

  task automatic load_frame(input int port, input int n, input bit sof_ok, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.d   = first + 8'(i);
      b.sof = sof_ok && (i == 0);
      b.eof = (i == n - 1);
      pq[port].push_back(b);
    end
  endtask

  // Sample bus and downstream away from the active edge
  always @(negedge rd_clk) begin
    pend_beat <= !bus.rd_src_rdy_n_in && !bus.rd_dst_rdy_n;
    pend_addr <= bus.rd_addr;
    if (!bus.out_src_rdy_n && !bus.out_dst_rdy_n)
      mon_q.push_back({bus.out_port, bus.out_data, bus.out_sof_n, bus.out_eof_n});
    if (!bus.out_src_rdy_n && (bus.rd_dst_rdy_n != bus.out_dst_rdy_n))
      mirror_err <= mirror_err + 1;
  end

  // FIFO bank model: registered chip-select, pop on bus beat, plus downstream ready driver
  initial begin
    logic [5:0] sel_addr;
    int         p;
    bit         tog;
    sel_addr = IDLE_A;
    tog      = 1'b0;
    bus.rd_data_in      = 8'h5A;
    bus.rd_sof_n_in     = 1'b1;
    bus.rd_eof_n_in     = 1'b1;
    bus.rd_src_rdy_n_in = 1'b1;
    bus.out_dst_rdy_n   = 1'b0;
    forever begin
      @(posedge rd_clk);
      #1;
      p = port_of(sel_addr);
      if (pend_beat && p >= 0 && pq[p].size() > 0) void'(pq[p].pop_front());
      sel_addr = pend_addr;
      p = port_of(sel_addr);
      if (p >= 0 && pq[p].size() > 0) begin
        bus.rd_data_in      = pq[p][0].d;
        bus.rd_sof_n_in     = ~pq[p][0].sof;
        bus.rd_eof_n_in     = ~pq[p][0].eof;
        bus.rd_src_rdy_n_in = 1'b0;
      end else begin
        bus.rd_data_in      = 8'h5A;
        bus.rd_sof_n_in     = 1'b1;
        bus.rd_eof_n_in     = 1'b1;
        bus.rd_src_rdy_n_in = 1'b1;
      end
      case (stall_mode)
        1: begin tog = ~tog; bus.out_dst_rdy_n = tog; end
        2: bus.out_dst_rdy_n = ($urandom_range(0, 9) < 3);
        default: bus.out_dst_rdy_n = 1'b0;
      endcase
    end
  end

  initial begin
    vec_t        vt [6];
    int          first_addr, first_out, last_out, m0, bad, nf, nd, len, nfr;
    bit          done, ok;
    logic [7:0]  base;
    logic [13:0] exp_q [$];
    int          flen [NP][$];
    bit          fok  [NP][$];
    logic [7:0]  fbase [NP][$];

    vt[0] = '{2, 5,  1'b1, 0, 1, 0, 6'h33};
    vt[1] = '{2, 5,  1'b1, 1, 1, 0, 6'h33};
    vt[2] = '{5, 3,  1'b0, 0, 0, 1, 6'h36};
    vt[3] = '{7, 1,  1'b1, 0, 1, 0, 6'h30};
    vt[4] = '{0, 1,  1'b0, 0, 0, 1, 6'h31};
    vt[5] = '{4, 16, 1'b1, 2, 1, 0, 6'h35};

    // Reset values and empty round-robin polling
    do_reset();
    @(negedge rd_clk);
    check("rst_addr", bus.rd_addr, IDLE_A);
    check("rst_dst_rdy_n", bus.rd_dst_rdy_n, 1);
    check("rst_src_rdy_n", bus.out_src_rdy_n, 1);
    check("rst_sof_eof_n", {bus.out_sof_n, bus.out_eof_n}, 2'b11);
    check("rst_data", bus.out_data, 0);
    check("rst_port", bus.out_port, 0);
    check("rst_frames", frame_count, 0);
    check("rst_desync", desync_count, 0);
    enable = 1'b1;
    bad = 0;
    for (int k = 0; k < 27; k++) begin
      @(negedge rd_clk);
      check("poll_addr", bus.rd_addr, BASE + 6'((k / 3) % NP));
      if (bus.rd_dst_rdy_n !== 1'b1 || bus.out_src_rdy_n !== 1'b1 || bus.out_data !== 8'h00) bad++;
    end
    check("poll_idle_outputs", bad, 0);
    check("poll_frames", frame_count, 0);

    // Table-driven single-frame scenarios
    for (int t = 0; t < 6; t++) begin
      do_reset();
      load_frame(vt[t].port, vt[t].nbytes, vt[t].sof_ok, 8'hA0);
      stall_mode = vt[t].stall;
      m0 = mirror_err;
      enable = 1'b1;
      first_addr = -1; first_out = -1; last_out = -1; done = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
        @(negedge rd_clk);
        if (first_addr < 0 && bus.rd_addr == BASE + 6'(vt[t].port)) first_addr = c;
        if (first_out < 0 && !bus.out_src_rdy_n) first_out = c;
        if (!bus.out_src_rdy_n && !bus.out_dst_rdy_n) last_out = c;
        if (!bus.rd_src_rdy_n_in && !bus.rd_dst_rdy_n && !bus.rd_eof_n_in) done = 1'b1;
      end
      check($sformatf("vec%0d_eof_seen", t), done, 1);
      @(negedge rd_clk);
      check($sformatf("vec%0d_next_addr", t), bus.rd_addr, vt[t].exp_next);
      check($sformatf("vec%0d_frames", t), frame_count, vt[t].exp_frames);
      check($sformatf("vec%0d_desync", t), desync_count, vt[t].exp_desync);
      check($sformatf("vec%0d_mirror", t), mirror_err - m0, 0);
      check($sformatf("vec%0d_out_beats", t), mon_q.size(), vt[t].sof_ok ? vt[t].nbytes : 0);
      if (vt[t].sof_ok) begin
        check($sformatf("vec%0d_latency", t), first_out - first_addr, 3);
        if (vt[t].stall == 0)
          check($sformatf("vec%0d_burst_len", t), last_out - first_out, vt[t].nbytes - 1);
        for (int i = 0; i < vt[t].nbytes && i < mon_q.size(); i++)
          check($sformatf("vec%0d_beat%0d", t, i), mon_q[i],
                {4'(vt[t].port), 8'hA0 + 8'(i), 1'(i != 0), 1'(i != vt[t].nbytes - 1)});
      end
    end

    // Enable dropped mid-frame: frame completes, then the block parks
    do_reset();
    load_frame(0, 10, 1'b1, 8'h10);
    load_frame(1, 2, 1'b1, 8'h50);
    enable = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge rd_clk);
      if (!bus.out_src_rdy_n) done = 1'b1;
    end
    check("en_drop_xfer_seen", done, 1);
    @(negedge rd_clk);
    enable = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge rd_clk);
      if (!bus.rd_src_rdy_n_in && !bus.rd_dst_rdy_n && !bus.rd_eof_n_in) done = 1'b1;
    end
    check("en_drop_eof_seen", done, 1);
    @(negedge rd_clk);
    check("en_drop_idle_addr", bus.rd_addr, IDLE_A);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge rd_clk);
      if (bus.rd_addr !== IDLE_A) bad++;
    end
    check("en_drop_stays_idle", bad, 0);
    check("en_drop_frames", frame_count, 1);
    check("en_drop_beats", mon_q.size(), 10);
    check("en_drop_port1_untouched", pq[1].size(), 2);

    // Reset pulsed in the middle of a transfer
    do_reset();
    load_frame(3, 8, 1'b1, 8'h70);
    enable = 1'b1;
    for (int c = 0; c < 100 && mon_q.size() < 2; c++) @(negedge rd_clk);
    check("rst_mid_started", mon_q.size() >= 2, 1);
    step();
    rd_sreset = 1'b1;
    step();
    rd_sreset = 1'b0;
    @(negedge rd_clk);
    check("rst_mid_addr", bus.rd_addr, IDLE_A);
    check("rst_mid_dst_rdy_n", bus.rd_dst_rdy_n, 1);
    check("rst_mid_out_idle", {bus.out_src_rdy_n, bus.out_sof_n, bus.out_eof_n, bus.out_data}, {3'b111, 8'h00});
    check("rst_mid_port_cnt", {bus.out_port, frame_count, desync_count}, 28'h0);
    bad = 0;
    foreach (mon_q[i]) if (mon_q[i][0] == 1'b0) bad++;
    check("rst_mid_no_eof", bad, 0);
    @(negedge rd_clk);
    check("rst_mid_restart_addr", bus.rd_addr, BASE);

    // desync_count saturates at FF
    do_reset();
    for (int i = 0; i < 258; i++) load_frame(0, 1, 1'b0, 8'(i));
    enable = 1'b1;
    for (int c = 0; c < 9000 && pq[0].size() > 0; c++) @(negedge rd_clk);
    check("sat_drained", pq[0].size(), 0);
    repeat (4) @(negedge rd_clk);
    check("sat_desync", desync_count, 8'hFF);
    check("sat_frames", frame_count, 0);
    check("sat_no_output", mon_q.size(), 0);

    // Randomized traffic against a frame-level round-robin reference
    for (int it = 0; it < 3; it++) begin
      do_reset();
      stall_mode = 2;
      m0 = mirror_err;
      exp_q.delete();
      nf = 0; nd = 0;
      for (int p = 0; p < NP; p++) begin
        flen[p].delete(); fok[p].delete(); fbase[p].delete();
        nfr = $urandom_range(0, 3);
        for (int f = 0; f < nfr; f++) begin
          len  = $urandom_range(1, 6);
          ok   = ($urandom_range(0, 6) != 0);
          base = 8'($urandom);
          load_frame(p, len, ok, base);
          flen[p].push_back(len); fok[p].push_back(ok); fbase[p].push_back(base);
        end
      end
      done = 1'b0;
      while (!done) begin
        done = 1'b1;
        for (int p = 0; p < NP; p++) begin
          if (flen[p].size() > 0) begin
            done = 1'b0;
            len = flen[p].pop_front(); ok = fok[p].pop_front(); base = fbase[p].pop_front();
            if (ok) begin
              nf++;
              for (int i = 0; i < len; i++)
                exp_q.push_back({4'(p), base + 8'(i), 1'(i != 0), 1'(i != len - 1)});
            end else nd++;
          end
        end
      end
      enable = 1'b1;
      for (int c = 0; c < 4000 && !(frame_count == 16'(nf) && desync_count == 8'(nd)); c++)
        @(negedge rd_clk);
      repeat (4) @(negedge rd_clk);
      check($sformatf("rnd%0d_frames", it), frame_count, nf);
      check($sformatf("rnd%0d_desync", it), desync_count, nd);
      check($sformatf("rnd%0d_beats", it), mon_q.size(), exp_q.size());
      check($sformatf("rnd%0d_mirror", it), mirror_err - m0, 0);
      bad = 0;
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
        if (mon_q[i] !== exp_q[i]) begin
          if (bad == 0) $display("FAIL rnd%0d_beat%0d: got %0h expected %0h", it, i, mon_q[i], exp_q[i]);
          bad++;
        end
      check($sformatf("rnd%0d_stream", it), bad, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_fifo_bus_poller.md
Name: rx_fifo_bus_poller

Overview:
- Read-side master for the shared tri-state FIFO read bus. Several address-decoded receive FIFOs hang on this bus.
- Polls FIFO addresses round-robin by driving rd_addr. After each address change it honours the 2-cycle chip-select pipeline, then probes for a start-of-frame.
- Forwards exactly one frame per probed FIFO onto a downstream LocalLink port, tagged with the port index. Feeds the SRU command/packet decoder.

Parameters:
- BaseAddr, 6'h30, rd_addr of port index 0; port i uses BaseAddr+i.
- NumPorts, 8, number of FIFOs polled (1..16). BaseAddr+NumPorts must be <= 64.
- IdleAddr, 6'h00, parking address. It must lie outside [BaseAddr, BaseAddr+NumPorts-1].

Ports:
- rd_clk  in  1  single clock for the whole block.
- rd_sreset  in  1  synchronous, active-high reset.
- enable  in  1  polling enable.
- rd_addr  out  6  FIFO select address.
- rd_data_in  in  8  shared bus data; only valid while a FIFO is selected.
- rd_sof_n_in  in  1  shared bus start-of-frame, active-low.
- rd_eof_n_in  in  1  shared bus end-of-frame, active-low.
- rd_src_rdy_n_in  in  1  shared bus source ready, active-low.
- rd_dst_rdy_n  out  1  destination ready to the selected FIFO, active-low.
- out_data  out  8  downstream data.
- out_sof_n  out  1  downstream start-of-frame, active-low.
- out_eof_n  out  1  downstream end-of-frame, active-low.
- out_src_rdy_n  out  1  downstream source ready, active-low.
- out_dst_rdy_n  in  1  downstream destination ready, active-low.
- out_port  out  4  index of the FIFO currently forwarding.
- frame_count  out  16  frames forwarded, wrapping.
- desync_count  out  8  frames discarded because of missing SOF, saturating.

Behaviour:
- Reset values: rd_addr=IdleAddr, rd_dst_rdy_n=1, out_src_rdy_n=1, out_sof_n=1, out_eof_n=1, out_data=0, out_port=0, frame_count=0, desync_count=0. State=IDLE, port index idx=0.
- Reset applies from any state, including mid-frame. The FIFO-side frame is abandoned and no partial frame is completed downstream.
- Beat definitions:
  - Bus beat = rd_src_rdy_n_in==0 && rd_dst_rdy_n==0.
  - Downstream beat = out_src_rdy_n==0 && out_dst_rdy_n==0.
- IDLE: rd_addr=IdleAddr. If enable=1, go to SELECT with rd_addr=BaseAddr+idx.
- SELECT (exactly 2 cycles):
  - rd_addr is held at BaseAddr+idx.
  - rd_dst_rdy_n=1 and all out_* valid/framing signals are inactive.
  - This covers the FIFO's registered chip-select (1 cycle) and its registered dst-ready gate (2 cycles). No bus beat can occur.
  - Then go to PROBE.
- PROBE (1 cycle, rd_dst_rdy_n=1), samples the bus:
  - rd_src_rdy_n_in=1: port empty. idx=(idx+1) mod NumPorts. Go to SELECT, or to IDLE if enable=0.
  - rd_src_rdy_n_in=0 and rd_sof_n_in=0: go to XFER and load out_port=idx.
  - rd_src_rdy_n_in=0 and rd_sof_n_in=1: desync. desync_count+1, saturating at 8'hFF. Go to DRAIN.
- XFER: combinational pass-through between bus and downstream.
  - out_data=rd_data_in, out_sof_n=rd_sof_n_in, out_eof_n=rd_eof_n_in, out_src_rdy_n=rd_src_rdy_n_in.
  - rd_dst_rdy_n=out_dst_rdy_n.
  - Zero added latency; downstream backpressure stalls the FIFO directly.
  - On a beat with rd_eof_n_in=0: frame_count+1, idx advances, go to SELECT of the next port (or IDLE if enable=0).
  - The address changes in the cycle after the EOF beat. rd_dst_rdy_n=1 from that cycle, so the old FIFO's still-open gate sees no further reads.
- DRAIN:
  - rd_dst_rdy_n=0, out_src_rdy_n=1, out_data=0.
  - Bytes are consumed and discarded until a bus beat with rd_eof_n_in=0, then advance idx as in XFER.
- enable=0:
  - Honoured only in IDLE, SELECT and PROBE (abort to IDLE, rd_addr=IdleAddr next cycle).
  - XFER and DRAIN always complete the current frame first.
- Outside XFER: out_data=0, out_sof_n=1, out_eof_n=1.
- Tri-state handover: old and new FIFO chip-selects both change one cycle after rd_addr changes, so there is no bus overlap.
- A single-byte frame (sof and eof on the same beat) is legal in both XFER and DRAIN.
- frame_count wraps FFFF->0000.

Test Plan:
- Reset, enable=1, all FIFOs empty -> rd_addr sequence 30,31,...,37,30, each held 3 cycles. rd_dst_rdy_n stays 1. frame_count=0.
- Port 2 holds a 5-byte frame A0..A4, out_dst_rdy_n=0 -> out_port=2. out_* delivers A0(sof)..A4(eof) on 5 consecutive cycles starting 3 cycles after rd_addr=32. frame_count=1. rd_addr=33 on the next cycle.
- Same frame with out_dst_rdy_n toggling 1,0,1,0 -> rd_dst_rdy_n mirrors it each cycle. No byte is lost or duplicated; all 5 bytes arrive in order.
- Port 5 presents data without SOF (3 bytes, eof on the 3rd) -> no out_src_rdy_n assertion. desync_count=1. Polling resumes at address 36.
- enable dropped mid-frame on port 0 -> the frame completes to EOF, then rd_addr=IdleAddr=00 and the block stays in IDLE.
- rd_sreset pulsed mid-XFER -> next cycle all outputs are at reset values and rd_addr=00. With enable=1, polling restarts at address 30.
